// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and helpers for the PLL reset/power-down sequencer.
package pll_rst_ctrl_pkg;

   typedef enum logic [2:0] {
      PWRDN,
      RESET,
      WAIT_LOCK,
      STABLE,
      RUN
   } state_e;

   localparam int CNT_W = 8;

   // Width of the shared state-duration counter; never narrower than one bit.
   function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                    input int stable_cycles);
      int m;
      m = rst_cycles;
      if (lock_timeout > m) m = lock_timeout;
      if (stable_cycles > m) m = stable_cycles;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/pll_rst_ctrl_sync_ff.sv
// N-stage synchronizer with asynchronous reset to 0.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLLE2 reset/power-down sequencer with LOCKED qualification and retry.
// Optional lock-loss counter enabled by defining PLL_RST_CTRL_LOSS_CNT_EN.
module pll_rst_ctrl
   import pll_rst_ctrl_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 125000,
   parameter int STABLE_CYCLES = 1024,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic             pll_locked_i,
   output logic             pll_rst_o,
   output logic             pll_pwrdwn_o,
   output logic             ready_o,
   output logic             err_o,
   output logic [CNT_W-1:0] retry_cnt_o,
   output logic [CNT_W-1:0] loss_cnt_o
);

   localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

   logic             lk_s;
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] retry_q, retry_d;
   logic             pll_rst_q, pll_rst_d;
   logic             pwrdwn_q, pwrdwn_d;
   logic             ready_q, ready_d;

   sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pll_locked_i),
      .q_o (lk_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RESET;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         pwrdwn_q  <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         pwrdwn_q  <= pwrdwn_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      retry_d = retry_q;
      unique case (state_q)
         PWRDN: begin
            if (enable_i) begin
               state_d = RESET;
               err_d   = 1'b0;
            end
         end
         RESET: begin
            if (!enable_i)               state_d = PWRDN;
            else if (cnt_q == RST_LAST)  state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (!enable_i)      state_d = PWRDN;
            else if (lk_s)      state_d = STABLE;
            else if (cnt_q == TO_LAST) begin
               state_d = RESET;
               err_d   = 1'b1;
               retry_d = sat_inc(retry_q);
            end
         end
         STABLE: begin
            if (!enable_i) state_d = PWRDN;
            else if (!lk_s) begin
               state_d = RESET;
               retry_d = sat_inc(retry_q);
            end else if (cnt_q == STB_LAST) begin
               state_d = RUN;
               err_d   = 1'b0;
            end
         end
         RUN: begin
            if (!enable_i)  state_d = PWRDN;
            else if (!lk_s) state_d = RESET;
         end
         default: state_d = RESET;
      endcase

      // Counter restarts on every state entry and only runs in timed states.
      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q == RESET || state_q == WAIT_LOCK || state_q == STABLE)
         cnt_d = cnt_q + 1'b1;
      else
         cnt_d = cnt_q;

      pll_rst_d = (state_d == PWRDN) || (state_d == RESET);
      pwrdwn_d  = (state_d == PWRDN);
      ready_d   = (state_d == RUN);
   end

`ifdef PLL_RST_CTRL_LOSS_CNT_EN
   logic [CNT_W-1:0] loss_q, loss_d;

   always_comb begin
      loss_d = loss_q;
      if (state_q == RUN && enable_i && !lk_s) loss_d = sat_inc(loss_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) loss_q <= '0;
      else     loss_q <= loss_d;
   end

   assign loss_cnt_o = loss_q;
`else
   assign loss_cnt_o = '0;
`endif

   assign pll_rst_o    = pll_rst_q;
   assign pll_pwrdwn_o = pwrdwn_q;
   assign ready_o      = ready_q;
   assign err_o        = err_q;
   assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed/randomized bench for pll_rst_ctrl; expectations derived from sequencing timing rules.
module tb_pll_rst_ctrl;

   localparam int RC = 4;
   localparam int LT = 20;
   localparam int SC = 8;
   localparam int SS = 2;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       enable_i;
   logic       pll_locked_i;
   logic       pll_rst_o;
   logic       pll_pwrdwn_o;
   logic       ready_o;
   logic       err_o;
   logic [7:0] retry_cnt_o;
   logic [7:0] loss_cnt_o;

   int total = 0;
   int bad   = 0;
   int n;
   int d;
   int exp_retry;
   int exp_loss;

   pll_rst_ctrl #(
      .RST_CYCLES   (RC),
      .LOCK_TIMEOUT (LT),
      .STABLE_CYCLES(SC),
      .SYNC_STAGES  (SS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .pll_locked_i (pll_locked_i),
      .pll_rst_o    (pll_rst_o),
      .pll_pwrdwn_o (pll_pwrdwn_o),
      .ready_o      (ready_o),
      .err_o        (err_o),
      .retry_cnt_o  (retry_cnt_o),
      .loss_cnt_o   (loss_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample just after the edge; ready must never overlap RST/PWRDWN.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("ready_exclusive", 32'(ready_o & (pll_rst_o | pll_pwrdwn_o)), 32'd0);
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return pll_rst_o;
         1:       return pll_pwrdwn_o;
         2:       return ready_o;
         default: return err_o;
      endcase
   endfunction

   task automatic wait_sig(input int which, input logic val, input int maxc, output int cnt);
      cnt = 0;
      while (sig(which) !== val && cnt < maxc) begin
         tick();
         cnt++;
      end
   endtask

   function automatic int sat8(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   initial begin
      rst = 1'b1; enable_i = 1'b0; pll_locked_i = 1'b0;
      exp_retry = 0; exp_loss = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pll_rst", 32'(pll_rst_o), 32'd1);
      chk("rst_pwrdwn", 32'(pll_pwrdwn_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_retry", 32'(retry_cnt_o), 32'd0);
      chk("rst_loss", 32'(loss_cnt_o), 32'd0);

      // First bring-up: RST pulse, then lock after a random delay.
      enable_i = 1'b1;
      rst = 1'b0;
      wait_sig(0, 1'b0, 50, n);
      chk("first_rst_pulse", n, RC);
      d = $urandom_range(0, 8);
      repeat (d) tick();
      pll_locked_i = 1'b1;
      wait_sig(2, 1'b1, 100, n);
      chk("lock_to_ready", n, SS + 1 + SC);
      chk("run_err", 32'(err_o), 32'd0);
      chk("run_retry", 32'(retry_cnt_o), 32'd0);
      chk("run_pll_rst", 32'(pll_rst_o), 32'd0);

      // Lock loss in RUN.
      d = $urandom_range(0, 5);
      repeat (d) tick();
      pll_locked_i = 1'b0;
      wait_sig(2, 1'b0, 20, n);
      chk("loss_to_ready_low", n, SS + 1);
      if (LOSS_EN) exp_loss = sat8(exp_loss);
      chk("loss_cnt_1", 32'(loss_cnt_o), exp_loss);
      chk("loss_pll_rst", 32'(pll_rst_o), 32'd1);
      chk("loss_err", 32'(err_o), 32'd0);

      // Lock timeout, then recovery.
      wait_sig(0, 1'b0, 50, n);
      chk("reset_len_after_loss", n, RC);
      wait_sig(3, 1'b1, 100, n);
      chk("timeout_len", n, LT);
      exp_retry = sat8(exp_retry);
      chk("timeout_retry", 32'(retry_cnt_o), exp_retry);
      chk("timeout_pll_rst", 32'(pll_rst_o), 32'd1);
      wait_sig(0, 1'b0, 50, n);
      chk("retry_rst_pulse", n, RC);
      chk("err_sticky", 32'(err_o), 32'd1);
      d = $urandom_range(0, 8);
      repeat (d) tick();
      pll_locked_i = 1'b1;
      wait_sig(2, 1'b1, 100, n);
      chk("relock_to_ready", n, SS + 1 + SC);
      chk("err_cleared_run", 32'(err_o), 32'd0);

      // Power-down from RUN and re-enable.
      enable_i = 1'b0;
      tick();
      chk("pd_pwrdwn", 32'(pll_pwrdwn_o), 32'd1);
      chk("pd_ready", 32'(ready_o), 32'd0);
      chk("pd_pll_rst", 32'(pll_rst_o), 32'd1);
      pll_locked_i = 1'b0;
      d = $urandom_range(1, 5);
      repeat (d) tick();
      chk("pd_hold", 32'(pll_pwrdwn_o), 32'd1);
      chk("pd_retry", 32'(retry_cnt_o), exp_retry);
      enable_i = 1'b1;
      wait_sig(1, 1'b0, 10, n);
      chk("pd_exit", n, 1);
      chk("pd_exit_rst", 32'(pll_rst_o), 32'd1);
      wait_sig(0, 1'b0, 50, n);
      chk("reenable_rst_pulse", n, RC);

      // One-cycle lock glitch during STABLE.
      pll_locked_i = 1'b1;
      repeat (SS + 1) tick();
      d = $urandom_range(0, 3);
      repeat (d) tick();
      pll_locked_i = 1'b0;
      tick();
      pll_locked_i = 1'b1;
      wait_sig(0, 1'b1, 20, n);
      chk("glitch_to_reset", n, 2);
      exp_retry = sat8(exp_retry);
      chk("glitch_retry", 32'(retry_cnt_o), exp_retry);
      chk("glitch_err", 32'(err_o), 32'd0);
      wait_sig(2, 1'b1, 100, n);
      chk("locked_through_reset", n, RC + 1 + SC);

      // Drive retry counter into saturation with repeated timeouts.
      pll_locked_i = 1'b0;
      wait_sig(2, 1'b0, 20, n);
      chk("loss2_to_ready_low", n, SS + 1);
      if (LOSS_EN) exp_loss = sat8(exp_loss);
      chk("loss_cnt_2", 32'(loss_cnt_o), exp_loss);
      for (int i = 0; i < 300; i++) begin
         wait_sig(0, 1'b0, 50, n);
         chk("sat_rst_pulse", n, RC);
         wait_sig(0, 1'b1, 50, n);
         chk("sat_timeout_len", n, LT);
         exp_retry = sat8(exp_retry);
         chk("sat_retry", 32'(retry_cnt_o), exp_retry);
      end
      chk("sat_final", 32'(retry_cnt_o), 32'd255);
      chk("sat_err", 32'(err_o), 32'd1);

      // err survives power-down and clears on leaving it.
      enable_i = 1'b0;
      tick();
      chk("pd2_err", 32'(err_o), 32'd1);
      chk("pd2_pwrdwn", 32'(pll_pwrdwn_o), 32'd1);
      enable_i = 1'b1;
      tick();
      chk("pd2_exit_err", 32'(err_o), 32'd0);
      chk("pd2_exit_pwrdwn", 32'(pll_pwrdwn_o), 32'd0);
      chk("counters_kept", 32'(retry_cnt_o), 32'd255);
      wait_sig(0, 1'b0, 50, n);
      chk("pd2_rst_pulse", n, RC);

      // Asynchronous reset in the middle of WAIT_LOCK.
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("async_pll_rst", 32'(pll_rst_o), 32'd1);
      chk("async_pwrdwn", 32'(pll_pwrdwn_o), 32'd0);
      chk("async_ready", 32'(ready_o), 32'd0);
      chk("async_err", 32'(err_o), 32'd0);
      chk("async_retry", 32'(retry_cnt_o), 32'd0);
      chk("async_loss", 32'(loss_cnt_o), 32'd0);
      tick();
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
